// File: rtl/imm_pkg.sv
// Shared decode constants for the immediate sequencer.
// ExtendSign encodings, RV32 opcodes, FSM states.
package imm_pkg;

  typedef enum logic [1:0] {
    EXT_I   = 2'b00,
    EXT_S   = 2'b01,
    EXT_B   = 2'b10,
    EXT_BAD = 2'b11
  } ext_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXT  = 2'b01,
    ST_HOLD = 2'b10
  } imm_state_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  function automatic ext_sel_e decode_sel(
    input logic [6:0] op
  );
    ext_sel_e sel;
    sel = EXT_BAD;
    unique case (1'b1)
      (op == OP_IMM),
      (op == OP_LOAD),
      (op == OP_JALR):   sel = EXT_I;
      (op == OP_STORE):  sel = EXT_S;
      (op == OP_BRANCH): sel = EXT_B;
      default:           sel = EXT_BAD;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/sign_extension.sv
// RV32 immediate extractor for decode.
// Select 2'b11 yields the U-type upper immediate.
module sign_extension
  import imm_pkg::*;
(
  output logic [31:0] out,
  input  logic [31:0] IR,
  input  logic [1:0]  ExtendSign
);

  // Pure combinational field gather and sign extension.
  always_comb begin
    out = '0;
    unique case (ExtendSign)
      EXT_I: out = {{20{IR[31]}}, IR[31:20]};
      EXT_S: out = {{20{IR[31]}}, IR[31:25], IR[11:7]};
      EXT_B: out = {{19{IR[31]}}, IR[31], IR[7],
                    IR[30:25], IR[11:8], 1'b0};
      default: out = {IR[31:12], 12'b0};
    endcase
  end

endmodule

// File: rtl/imm_gen_ctrl.sv
// Valid/ready sequencer around sign_extension.
// Optional per-class counters under IMM_STATS_EN.
module imm_gen_ctrl
  import imm_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int ILLEGAL_ZERO = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_ir,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_imm,
  output logic [31:0]       out_ir,
  output logic              out_illegal
`ifdef IMM_STATS_EN
  ,
  output logic [CNT_W-1:0]  cnt_i,
  output logic [CNT_W-1:0]  cnt_s,
  output logic [CNT_W-1:0]  cnt_b,
  output logic [CNT_W-1:0]  cnt_ill
`endif
);

  imm_state_e  state, state_n;
  logic [31:0] ir_q;
  ext_sel_e    sel_q;
  logic        ill_q;
  logic        acc;
  logic        cap;
  ext_sel_e    dec_sel;
  logic        dec_ill;
  logic [31:0] ext_out;

  assign dec_sel = decode_sel(in_ir[6:0]);
  assign dec_ill = (dec_sel == EXT_BAD);
  assign acc     = in_valid & in_ready;

  sign_extension u_ext (
    .out        (ext_out),
    .IR         (ir_q),
    .ExtendSign (sel_q)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    cap       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = ST_EXT;
      end
      ST_EXT: begin
        cap     = 1'b1;
        state_n = ST_HOLD;
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready)
          state_n = in_valid ? ST_EXT : ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
    if (rst) in_ready = 1'b0;
  end

  // Instruction capture on accept, result capture in EXT.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_q        <= '0;
      sel_q       <= EXT_I;
      ill_q       <= 1'b0;
      out_imm     <= '0;
      out_ir      <= '0;
      out_illegal <= 1'b0;
    end else begin
      if (acc) begin
        ir_q  <= in_ir;
        sel_q <= dec_sel;
        ill_q <= dec_ill;
      end
      if (cap) begin
        out_imm     <= (ill_q && ILLEGAL_ZERO != 0)
                       ? 32'h0 : ext_out;
        out_ir      <= ir_q;
        out_illegal <= ill_q;
      end
    end
  end

`ifdef IMM_STATS_EN
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  // Saturating per-class accept counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_i   <= '0;
      cnt_s   <= '0;
      cnt_b   <= '0;
      cnt_ill <= '0;
    end else if (acc) begin
      unique case (dec_sel)
        EXT_I: if (cnt_i != '1) cnt_i <= cnt_i + ONE;
        EXT_S: if (cnt_s != '1) cnt_s <= cnt_s + ONE;
        EXT_B: if (cnt_b != '1) cnt_b <= cnt_b + ONE;
        default:
          if (cnt_ill != '1) cnt_ill <= cnt_ill + ONE;
      endcase
    end
  end
`else
  logic [31:0] unused_cnt_w;
  assign unused_cnt_w = 32'(CNT_W);
`endif

endmodule

// File: tb/tb_imm_gen_ctrl.sv
// Directed bench for imm_gen_ctrl.
// Define IMM_STATS_EN to also exercise the counters.
module tb_imm_gen_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_ir;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  logic [31:0] out_ir;
  logic        out_illegal;
`ifdef IMM_STATS_EN
  logic [1:0]  cnt_i, cnt_s, cnt_b, cnt_ill;
`endif

  int errs;
  int checks;

  imm_gen_ctrl #(
`ifdef IMM_STATS_EN
    .CNT_W        (2),
`else
    .CNT_W        (16),
`endif
    .ILLEGAL_ZERO (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_ir       (in_ir),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_imm     (out_imm),
    .out_ir      (out_ir),
    .out_illegal (out_illegal)
`ifdef IMM_STATS_EN
    ,
    .cnt_i       (cnt_i),
    .cnt_s       (cnt_s),
    .cnt_b       (cnt_b),
    .cnt_ill     (cnt_ill)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(
    input string       tag,
    input logic [31:0] ir,
    input logic [31:0] imm,
    input logic        ill
  );
    in_ir     = ir;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    chk({tag, ".rdy"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    in_ir    = 32'hDEADBEEF;
    chk({tag, ".ext_vld"}, 32'(out_valid), 32'd0);
    chk({tag, ".ext_rdy"}, 32'(in_ready), 32'd0);
    step();
    chk({tag, ".vld"}, 32'(out_valid), 32'd1);
    chk({tag, ".imm"}, out_imm, imm);
    chk({tag, ".ir"}, out_ir, ir);
    chk({tag, ".ill"}, 32'(out_illegal), 32'(ill));
    step();
    chk({tag, ".done"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    errs      = 0;
    checks    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_ir     = 32'h0;
    out_ready = 1'b1;
    step();
    step();
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_imm", out_imm, 32'h0);
    chk("rst.out_ir", out_ir, 32'h0);
    chk("rst.out_ill", 32'(out_illegal), 32'd0);
    rst = 1'b0;
    #1;
    chk("rel.in_ready", 32'(in_ready), 32'd1);
    step();

    run_one("addi", 32'hFF000093, 32'hFFFFFFF0, 1'b0);
    run_one("sw", 32'hFE112E23, 32'hFFFFFFFC, 1'b0);
    run_one("beq", 32'h00000463, 32'h00000008, 1'b0);
    run_one("lw", 32'h7FF02083, 32'h000007FF, 1'b0);
    run_one("lui", 32'h00000037, 32'h00000000, 1'b1);
    run_one("jal", 32'hFFFFF0EF, 32'h00000000, 1'b1);

    // Backpressure in HOLD with a pending instruction.
    in_ir     = 32'hFF000093;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    step();
    in_ir = 32'hFE112E23;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp.vld", 32'(out_valid), 32'd1);
      chk("bp.imm", out_imm, 32'hFFFFFFF0);
      chk("bp.ir", out_ir, 32'hFF000093);
      chk("bp.rdy", 32'(in_ready), 32'd0);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp.rdy_rel", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("bp.ext_vld", 32'(out_valid), 32'd0);
    step();
    chk("bp.vld2", 32'(out_valid), 32'd1);
    chk("bp.imm2", out_imm, 32'hFFFFFFFC);
    chk("bp.ir2", out_ir, 32'hFE112E23);
    step();
    chk("bp.idle", 32'(out_valid), 32'd0);

    // Reset while in EXT.
    in_ir    = 32'h00000463;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    rst      = 1'b1;
    step();
    chk("mid.vld", 32'(out_valid), 32'd0);
    chk("mid.imm", out_imm, 32'h0);
    chk("mid.ir", out_ir, 32'h0);
    chk("mid.rdy", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("mid.rdy_rel", 32'(in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid.stale", 32'(out_valid), 32'd0);
    end

`ifdef IMM_STATS_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    for (int i = 0; i < 4; i++)
      run_one("cnt", 32'hFF000093, 32'hFFFFFFF0, 1'b0);
    chk("cnt_i", 32'(cnt_i), 32'd3);
    chk("cnt_s", 32'(cnt_s), 32'd0);
    chk("cnt_b", 32'(cnt_b), 32'd0);
    chk("cnt_ill", 32'(cnt_ill), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected done");
    $fatal(1, "timeout");
  end

endmodule
